// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM encoding and default width.
package serial_arith_pkg;

    localparam int unsigned DEFAULT_W = 8;

    localparam int unsigned STATE_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit combinational subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b mod 2^W) processing one bit per clock, LSB first.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow
);

    localparam int unsigned CNT_W = $clog2(W);

    logic [STATE_W-1:0] state_q, state_d;
    logic [W-1:0]       a_sr_q, a_sr_d;
    logic [W-1:0]       b_sr_q, b_sr_d;
    logic [W-1:0]       res_sr_q, res_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic [W-1:0]       diff_q, diff_d;
    logic               borrow_out_q, borrow_out_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               cell_d;
    logic               cell_bout;

    full_subtractor u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_sr_d     = res_sr_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    res_sr_d = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d   = {1'b0, a_sr_q[W-1:1]};
                b_sr_d   = {1'b0, b_sr_q[W-1:1]};
                res_sr_d = {cell_d, res_sr_q[W-1:1]};
                borrow_d = cell_bout;
                // Counter parks at zero on the last bit instead of wrapping
                if (cnt_q == CNT_W'(W - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                done_d       = 1'b1;
                diff_d       = res_sr_q;
                borrow_out_d = borrow_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_sr_q     <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_sr_q     <= res_sr_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at W=4 and W=8.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       s4;
    logic [3:0] a4, b4, diff4;
    logic       busy4, done4, borrow4;

    logic       s8;
    logic [7:0] a8, b8, diff8;
    logic       busy8, done8, borrow8;

    int n_cmp = 0;
    int n_bad = 0;
    int done4_cnt = 0;
    int done8_cnt = 0;

    logic [4:0] exp4_q[$];
    logic [8:0] exp8_q[$];
    logic [4:0] e4;
    logic [8:0] e8;
    logic [3:0] last4 = 4'd0;
    logic [7:0] last8 = 8'd0;

    always #5 clk = ~clk;

    serial_subtractor #(.W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    serial_subtractor #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected result whenever a done pulse is seen
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            done4_cnt++;
            if (exp4_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut4 unexpected done: got diff %0h borrow %0b, expected no pulse", diff4, borrow4);
            end else begin
                e4 = exp4_q.pop_front();
                check("dut4 result {borrow,diff}", {27'd0, borrow4, diff4}, {27'd0, e4});
            end
        end
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            done8_cnt++;
            if (exp8_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut8 unexpected done: got diff %0h borrow %0b, expected no pulse", diff8, borrow8);
            end else begin
                e8 = exp8_q.pop_front();
                check("dut8 result {borrow,diff}", {23'd0, borrow8, diff8}, {23'd0, e8});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp, input string name);
        int k;
        int bc;
        bit stable;
        exp4_q.push_back(exp);
        a4 = a; b4 = b; s4 = 1'b1;
        tick();
        s4 = 1'b0; a4 = ~a; b4 = ~b;
        k = 0; bc = 0; stable = 1'b1;
        while (done4 !== 1'b1 && k < 14) begin
            if (busy4 === 1'b1) bc++;
            if (diff4 !== last4) stable = 1'b0;
            tick();
            k++;
        end
        check({name, " latency"}, k, 5);
        check({name, " busy cycles"}, bc, 5);
        check({name, " busy low at done"}, {31'd0, busy4}, 0);
        check({name, " diff held during run"}, {31'd0, stable}, 1);
        last4 = exp[3:0];
        tick();
        check({name, " done one cycle"}, {31'd0, done4}, 0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string name);
        int k;
        logic [8:0] exp;
        exp[8]   = (a < b);
        exp[7:0] = a - b;
        exp8_q.push_back(exp);
        a8 = a; b8 = b; s8 = 1'b1;
        tick();
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        k = 0;
        while (done8 !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({name, " latency"}, k, 9);
        last8 = exp[7:0];
        tick();
    endtask

    initial begin
        int c0;
        int k;
        int nd;
        int last;
        bit stable;

        rst_n = 1'b0;
        s4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        s8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        tick();
        tick();
        check("reset busy4", {31'd0, busy4}, 0);
        check("reset done4", {31'd0, done4}, 0);
        check("reset diff4/borrow4", {27'd0, borrow4, diff4}, 0);
        check("reset diff8/borrow8", {23'd0, borrow8, diff8}, 0);
        rst_n = 1'b1;
        tick();

        run4(4'd5, 4'd3, {1'b0, 4'd2},  "5-3");
        run4(4'd3, 4'd5, {1'b1, 4'hE},  "3-5");
        run4(4'd0, 4'd1, {1'b1, 4'hF},  "0-1");
        run4(4'hF, 4'hF, {1'b0, 4'h0},  "F-F");

        // Start and operand changes during RUN must be ignored
        c0 = done4_cnt;
        exp4_q.push_back({1'b0, 4'd7});
        a4 = 4'd9; b4 = 4'd2; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        tick();
        tick();
        a4 = 4'd1; b4 = 4'd8; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        repeat (12) tick();
        check("mid-run start ignored, done count", done4_cnt - c0, 1);
        check("mid-run diff4", {28'd0, diff4}, 7);
        last4 = 4'd7;

        // Start held high: one result every W+2 cycles
        exp8_q.push_back({1'b0, 8'd145});
        exp8_q.push_back({1'b0, 8'd145});
        exp8_q.push_back({1'b0, 8'd145});
        a8 = 8'd200; b8 = 8'd55; s8 = 1'b1;
        nd = 0; k = 0; last = -1; stable = 1'b1;
        while (nd < 3 && k < 100) begin
            tick();
            k++;
            if (done8 === 1'b1) begin
                if (last >= 0) check("back-to-back interval", k - last, 10);
                last = k;
                nd++;
                if (nd == 3) s8 = 1'b0;
            end else if (nd > 0 && diff8 !== 8'd145) begin
                stable = 1'b0;
            end
        end
        check("back-to-back done count", nd, 3);
        check("back-to-back diff stable", {31'd0, stable}, 1);
        last8 = 8'd145;
        tick();
        tick();
        check("back-to-back stops after start drop", {31'd0, busy8}, 0);

        // Asynchronous reset in the middle of RUN
        c0 = done4_cnt;
        a4 = 4'd5; b4 = 4'd3; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        tick();
        tick();
        check("busy4 before reset", {31'd0, busy4}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset busy4", {31'd0, busy4}, 0);
        check("async reset done4", {31'd0, done4}, 0);
        check("async reset diff4/borrow4", {27'd0, borrow4, diff4}, 0);
        check("async reset diff8/borrow8", {23'd0, borrow8, diff8}, 0);
        last4 = 4'd0;
        last8 = 8'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("no done for discarded op", done4_cnt - c0, 0);
        run4(4'd7, 4'd9, {1'b1, 4'hE}, "post-reset 7-9");

        run8(8'd0,   8'd0,   "8b 0-0");
        run8(8'd0,   8'd255, "8b 0-255");
        run8(8'd255, 8'd0,   "8b 255-0");
        run8(8'd128, 8'd127, "8b 128-127");
        run8(8'd127, 8'd128, "8b 127-128");
        for (int i = 0; i < 1000; i++) begin
            run8(8'($urandom), 8'($urandom), "8b sweep");
        end

        repeat (4) tick();
        check("dut4 queue drained", exp4_q.size(), 0);
        check("dut8 queue drained", exp8_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not complete, expected finish before 1000000 time units");
        $fatal(1, "timeout");
    end

endmodule
